sound_length_unit: RTL

//  Multi-channel length counter for the APU, replacing per-channel length logic.

---
 rtl/sound_length_unit_pkg.sv | 17 +
 rtl/sound_length_unit_slice.sv | 108 ++++++++++
 rtl/sound_length_unit.sv | 46 ++++
 3 files changed

// File: rtl/sound_length_unit_pkg.sv
// Shared constants for the sound length-counter blocks.
// Holds the channel index names, the counter widths and the default width mask.
package sound_length_unit_pkg;

  localparam int SND_CH_NUM   = 4;
  localparam int SND_WMAX     = 8;
  localparam int SND_NARROW_W = 6;

  // Channel 2 (the wave channel) has the long 8-bit length; the others use 6 bits.
  localparam logic [SND_CH_NUM-1:0] SND_WIDE_MASK = 4'b0100;

  localparam int SND_CH_SQ1   = 0;
  localparam int SND_CH_SQ2   = 1;
  localparam int SND_CH_WAVE  = 2;
  localparam int SND_CH_NOISE = 3;

endpackage

// File: rtl/sound_length_unit_slice.sv
// One channel of the length counter: remaining count, length-enable bit,
// channel enable and the expiry pulse. Width W is 6 or WMAX.
// Optional DMG extra-clock behaviour is built when SOUND_LEN_QUIRK_EN is defined.
module sound_length_slice
  import sound_length_unit_pkg::*;
#(
  parameter int W    = SND_NARROW_W,
  parameter int WMAX = SND_WMAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            len_tick,
  input  logic            seq_odd,
  input  logic            len_wr,
  input  logic [WMAX-1:0] len_data,
  input  logic            len_en_wr,
  input  logic            len_en_d,
  input  logic            trigger,
  input  logic            dac_on,
  output logic            enable,
  output logic            expired
);

  localparam logic [W:0] FULL    = {1'b1, {W{1'b0}}};
  localparam logic [W:0] FULL_M1 = {1'b0, {W{1'b1}}};
  localparam logic [W:0] ONE     = {{W{1'b0}}, 1'b1};

  logic [W:0] r_rem;
  logic       r_len_en;
  logic       r_enable;
  logic       r_expired;

  logic [W:0] w_rem_next;
  logic [W:0] w_rem_base;
  logic [W:0] w_reload;
  logic [W:0] w_load_val;
  logic       w_len_en_next;
  logic       w_enable_next;
  logic       w_expired_next;
  logic       w_tick_dec;
  logic       w_quirk_dec;
  logic       w_unused_len_data;

  // Bits of len_data above W carry no meaning for a narrow channel.
  assign w_unused_len_data = ^len_data;
  assign w_load_val        = FULL - {1'b0, len_data[W-1:0]};
  assign w_len_en_next     = len_en_wr ? len_en_d : r_len_en;
  assign w_tick_dec        = len_tick && r_len_en && (r_rem != '0);

`ifdef SOUND_LEN_QUIRK_EN
  // Enabling length during the non-clocking half of the sequencer clocks it once.
  assign w_quirk_dec = len_en_wr && len_en_d && !r_len_en && seq_odd && (r_rem != '0);
  assign w_reload    = (w_len_en_next && seq_odd) ? FULL_M1 : FULL;
`else
  logic w_unused_seq_odd;
  assign w_unused_seq_odd = seq_odd;
  assign w_quirk_dec      = 1'b0;
  assign w_reload         = (FULL_M1 == '0) ? FULL_M1 : FULL;
`endif

  assign w_rem_base = w_quirk_dec ? (r_rem - ONE) : r_rem;

  // Next-state selection in priority order: DAC off, trigger, length write, tick.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_rem_next     = w_rem_base;
    w_enable_next  = r_enable;
    w_expired_next = 1'b0;
    if (!dac_on) begin
      // DAC off silences the channel, but the counter itself keeps running.
      w_enable_next = 1'b0;
      if (w_tick_dec) w_rem_next = r_rem - ONE;
      w_expired_next = (w_tick_dec || w_quirk_dec) && (w_rem_next == '0);
    end else if (trigger) begin
      w_enable_next = 1'b1;
      if (w_rem_base == '0) w_rem_next = w_reload;
    end else if (len_wr) begin
      w_rem_next = w_load_val;
    end else begin
      if (w_tick_dec) w_rem_next = r_rem - ONE;
      if ((w_tick_dec || w_quirk_dec) && (w_rem_next == '0)) begin
        w_enable_next  = 1'b0;
        w_expired_next = 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the reset branch is asynchronous, so outputs clear without waiting for clk.
    if (!rst_n) begin
      r_rem     <= '0;
      r_len_en  <= 1'b0;
      r_enable  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_rem     <= w_rem_next;
      r_len_en  <= w_len_en_next;
      r_enable  <= w_enable_next;
      r_expired <= w_expired_next;
    end
  end

  assign enable  = r_enable;
  assign expired = r_expired;

endmodule

// File: rtl/sound_length_unit.sv
// Multi-channel APU length counter: CH_NUM independent slices sharing one
// length strobe. Optional macro: SOUND_LEN_QUIRK_EN (DMG extra-clock behaviour).
module sound_length_unit
  import sound_length_unit_pkg::*;
#(
  parameter int                  CH_NUM    = SND_CH_NUM,
  parameter int                  WMAX      = SND_WMAX,
  parameter logic [CH_NUM-1:0]   WIDE_MASK = SND_WIDE_MASK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     len_tick,
  input  logic                     seq_odd,
  input  logic [CH_NUM-1:0]        len_wr,
  input  logic [CH_NUM*WMAX-1:0]   len_data,
  input  logic [CH_NUM-1:0]        len_en_wr,
  input  logic [CH_NUM-1:0]        len_en_d,
  input  logic [CH_NUM-1:0]        trigger,
  input  logic [CH_NUM-1:0]        dac_on,
  output logic [CH_NUM-1:0]        enable,
  output logic [CH_NUM-1:0]        expired
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    localparam int W = WIDE_MASK[i] ? WMAX : SND_NARROW_W;

    sound_length_slice #(
      .W    (W),
      .WMAX (WMAX)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .len_tick  (len_tick),
      .seq_odd   (seq_odd),
      .len_wr    (len_wr[i]),
      .len_data  (len_data[i*WMAX +: WMAX]),
      .len_en_wr (len_en_wr[i]),
      .len_en_d  (len_en_d[i]),
      .trigger   (trigger[i]),
      .dac_on    (dac_on[i]),
      .enable    (enable[i]),
      .expired   (expired[i])
    );
  end

endmodule
